// File: rtl/smvm_stream_tx.sv
// SMVM input transmitter: buffers one sparse job from a ready/valid
// loader and replays it on the SMVM serial pins as one burst.
module smvm_stream_tx #(
  parameter int MAX_COLS  = 128,
  parameter int NNZ_DEPTH = 256,
  parameter int GAP       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  input  logic        s_last,
  output logic [7:0]  m_val,
  output logic        m_ipv,
  output logic [2:0]  m_col,
  output logic        m_valid,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int VAW = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
  localparam int NAW = (NNZ_DEPTH > 1) ? $clog2(NNZ_DEPTH) : 1;

  typedef enum logic [3:0] {
    IDLE, L_COLS, L_NNZ, L_VEC, L_NZ,
    T_ROWS, T_COLS, T_VEC, T_VAL, T_IDX,
    T_GAP, DRAIN
  } state_t;

  state_t      state, nxt;
  logic [15:0] cnt, cnt_n;
  logic [7:0]  rows_q, rows_n;
  logic [7:0]  cols_q, cols_n;
  logic [8:0]  nnz_q, nnz_n;
  logic [15:0] cols_w, nnz_w;
  logic        acc, vec_we, nz_we;
  logic        err_n, done_n;
  logic        ov_n, oi_n;
  logic [7:0]  oval_n;
  logic [2:0]  ocol_n;
  logic        bad_c, bad_n;
  logic [15:0] nz_rd;

  logic [7:0]  vec_ram [MAX_COLS];
  logic [15:0] nz_ram  [NNZ_DEPTH];

  assign s_ready = ~rst & (state inside
    {IDLE, L_COLS, L_NNZ, L_VEC, L_NZ, DRAIN});
  assign acc     = s_valid & s_ready;
  assign busy    = (state != IDLE);
  assign cols_w  = 16'(cols_q);
  assign nnz_w   = 16'(nnz_q);
  assign bad_c   = (s_data[7:0] == 8'd0) ||
                   (32'(s_data[7:0]) > MAX_COLS);
  assign bad_n   = (s_data[8:0] == 9'd0) ||
                   (32'(s_data[8:0]) > NNZ_DEPTH);
  assign nz_rd   = nz_ram[cnt_n[NAW-1:0]];

  always_comb begin
    nxt    = state;
    cnt_n  = cnt;
    rows_n = rows_q;
    cols_n = cols_q;
    nnz_n  = nnz_q;
    vec_we = 1'b0;
    nz_we  = 1'b0;
    err_n  = 1'b0;
    done_n = 1'b0;
    unique case (state)
      IDLE: if (acc) begin
        rows_n = s_data[7:0];
        if (s_last) err_n = 1'b1;
        else nxt = L_COLS;
      end
      L_COLS: if (acc) begin
        cols_n = s_data[7:0];
        if (s_last || bad_c) begin
          err_n = 1'b1;
          nxt   = s_last ? IDLE : DRAIN;
        end else nxt = L_NNZ;
      end
      L_NNZ: if (acc) begin
        nnz_n = s_data[8:0];
        if (s_last || bad_n) begin
          err_n = 1'b1;
          nxt   = s_last ? IDLE : DRAIN;
        end else begin
          nxt   = L_VEC;
          cnt_n = 16'd0;
        end
      end
      L_VEC: if (acc) begin
        vec_we = 1'b1;
        if (s_last) begin
          err_n = 1'b1;
          nxt   = IDLE;
        end else if (cnt == cols_w - 16'd1) begin
          nxt   = L_NZ;
          cnt_n = 16'd0;
        end else cnt_n = cnt + 16'd1;
      end
      L_NZ: if (acc) begin
        nz_we = 1'b1;
        if (cnt == nnz_w - 16'd1) begin
          if (s_last) begin
            nxt   = T_ROWS;
            cnt_n = 16'd0;
          end else begin
            err_n = 1'b1;
            nxt   = DRAIN;
          end
        end else if (s_last) begin
          err_n = 1'b1;
          nxt   = IDLE;
        end else cnt_n = cnt + 16'd1;
      end
      T_ROWS: nxt = T_COLS;
      T_COLS: begin
        nxt   = T_VEC;
        cnt_n = 16'd0;
      end
      T_VEC: if (cnt == cols_w - 16'd1) begin
        nxt   = T_VAL;
        cnt_n = 16'd0;
      end else cnt_n = cnt + 16'd1;
      T_VAL: nxt = T_IDX;
      T_IDX: if (cnt == nnz_w - 16'd1) begin
        nxt    = T_GAP;
        cnt_n  = 16'd0;
        done_n = 1'b1;
      end else begin
        nxt   = T_VAL;
        cnt_n = cnt + 16'd1;
      end
      T_GAP: if (cnt == 16'(GAP - 1)) begin
        nxt   = IDLE;
        cnt_n = 16'd0;
      end else cnt_n = cnt + 16'd1;
      DRAIN: if (acc && s_last) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the next state.
  always_comb begin
    ov_n   = 1'b0;
    oval_n = 8'd0;
    oi_n   = 1'b0;
    ocol_n = 3'd0;
    unique case (nxt)
      T_ROWS: begin
        ov_n = 1'b1;
        {oval_n, oi_n, ocol_n} = {4'h0, rows_q};
      end
      T_COLS: begin
        ov_n = 1'b1;
        {oval_n, oi_n, ocol_n} = {4'h0, cols_q};
      end
      T_VEC: begin
        ov_n   = 1'b1;
        oval_n = vec_ram[cnt_n[VAW-1:0]];
      end
      T_VAL: begin
        ov_n   = 1'b1;
        oval_n = nz_rd[7:0];
        oi_n   = nz_rd[15];
      end
      T_IDX: begin
        ov_n = 1'b1;
        {oval_n, oi_n, ocol_n} = {5'h0, nz_rd[14:8]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 16'd0;
      rows_q  <= 8'd0;
      cols_q  <= 8'd0;
      nnz_q   <= 9'd0;
      m_valid <= 1'b0;
      m_val   <= 8'd0;
      m_ipv   <= 1'b0;
      m_col   <= 3'd0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= nxt;
      cnt     <= cnt_n;
      rows_q  <= rows_n;
      cols_q  <= cols_n;
      nnz_q   <= nnz_n;
      m_valid <= ov_n;
      m_val   <= oval_n;
      m_ipv   <= oi_n;
      m_col   <= ocol_n;
      done    <= done_n;
      err     <= err_n;
    end
  end

  always_ff @(posedge clk) begin
    if (vec_we) vec_ram[cnt[VAW-1:0]] <= s_data[7:0];
    if (nz_we)  nz_ram[cnt[NAW-1:0]]  <= s_data;
  end

endmodule

// File: tb/tb_smvm_stream_tx.sv
// Directed bench for smvm_stream_tx: burst contents, loader
// bubbles, full-size job, header/s_last errors, reset mid-burst.
module tb_smvm_stream_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid, s_ready, s_last;
  logic [15:0] s_data;
  logic [7:0]  m_val;
  logic        m_ipv, m_valid;
  logic [2:0]  m_col;
  logic        busy, done, err;

  always #5 clk = ~clk;

  smvm_stream_tx dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last),
    .m_val(m_val), .m_ipv(m_ipv), .m_col(m_col),
    .m_valid(m_valid), .busy(busy),
    .done(done), .err(err)
  );

  int checks = 0;
  int failures = 0;

  logic [16:0] job [0:511];
  logic [11:0] cap [0:1023];
  logic [11:0] e1  [0:8];
  int cap_n, segs, done_cnt, err_cnt;
  int cyc, first, done_at, rdy_tx;
  logic prev_v;
  logic clr = 1'b1;

  always @(negedge clk) begin
    if (clr) begin
      cap_n <= 0; segs <= 0; done_cnt <= 0;
      err_cnt <= 0; cyc <= 0; first <= 0;
      done_at <= 0; rdy_tx <= 0; prev_v <= 1'b0;
    end else begin
      cyc    <= cyc + 1;
      prev_v <= m_valid;
      if (m_valid) begin
        if (cap_n < 1024) cap[cap_n] <= {m_val, m_ipv, m_col};
        cap_n <= cap_n + 1;
        if (!prev_v) begin
          segs  <= segs + 1;
          first <= cyc;
        end
        if (s_ready) rdy_tx <= rdy_tx + 1;
      end
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_at  <= cyc - first + 1;
      end
      if (err) err_cnt <= err_cnt + 1;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon;
    clr = 1'b1;
    @(negedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic send_job(input int n, input bit tog);
    for (int i = 0; i < n; i++) begin
      int w;
      w = 0;
      s_valid = 1'b1;
      s_data  = job[i][15:0];
      s_last  = job[i][16];
      while (!s_ready && w < 100) begin
        step();
        w++;
      end
      if (w >= 100) chk("send_timeout", 1, 0);
      step();
      s_valid = 1'b0;
      s_last  = 1'b0;
      if (tog) step();
    end
  endtask

  task automatic wait_idle;
    int w;
    w = 0;
    while (busy && w < 3000) begin
      step();
      w++;
    end
    chk("idle_timeout", busy, 0);
    repeat (2) step();
  endtask

  task automatic load_t1;
    job[0] = {1'b0, 16'h0002};
    job[1] = {1'b0, 16'h0003};
    job[2] = {1'b0, 16'h0002};
    job[3] = {1'b0, 16'h0005};
    job[4] = {1'b0, 16'h00FD};
    job[5] = {1'b0, 16'h0007};
    job[6] = {1'b0, 16'h0204};
    job[7] = {1'b1, 16'h80FF};
  endtask

  task automatic check_t1(input string p);
    chk({p, "_len"}, cap_n, 9);
    chk({p, "_segs"}, segs, 1);
    chk({p, "_done_cnt"}, done_cnt, 1);
    chk({p, "_done_at"}, done_at, 10);
    chk({p, "_err"}, err_cnt, 0);
    chk({p, "_rdy_tx"}, rdy_tx, 0);
    for (int i = 0; i < 9; i++)
      chk($sformatf("%s_beat%0d", p, i), cap[i], e1[i]);
  endtask

  initial begin
    e1[0] = 12'h002; e1[1] = 12'h003; e1[2] = 12'h050;
    e1[3] = 12'hFD0; e1[4] = 12'h070; e1[5] = 12'h040;
    e1[6] = 12'h002; e1[7] = 12'hFF8; e1[8] = 12'h000;
    rst = 1'b1;
    s_valid = 1'b0;
    s_last = 1'b0;
    s_data = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_m_word", {m_val, m_ipv, m_col}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_s_ready", s_ready, 1);
    clear_mon();

    // T1
    load_t1();
    send_job(8, 1'b0);
    wait_idle();
    check_t1("t1");
    clear_mon();

    // T2
    send_job(8, 1'b1);
    wait_idle();
    check_t1("t2");
    clear_mon();

    // T3
    job[0] = {1'b0, 16'h0001};
    job[1] = {1'b0, 16'h0080};
    job[2] = {1'b0, 16'h0100};
    for (int i = 0; i < 128; i++)
      job[3 + i] = {1'b0, 8'h00, 8'(i)};
    for (int k = 0; k < 256; k++)
      job[131 + k] = {(k == 255), 1'(k), 7'(k % 128), 8'(k)};
    send_job(387, 1'b0);
    wait_idle();
    chk("t3_len", cap_n, 642);
    chk("t3_segs", segs, 1);
    chk("t3_done_cnt", done_cnt, 1);
    chk("t3_err", err_cnt, 0);
    chk("t3_rows", cap[0], 12'h001);
    chk("t3_cols", cap[1], 12'h080);
    chk("t3_vec5", cap[7], 12'h050);
    chk("t3_vec127", cap[129], 12'h7F0);
    chk("t3_nz1_val", cap[132], 12'h018);
    chk("t3_nz1_idx", cap[133], 12'h001);
    chk("t3_last_val", cap[640], 12'hFF8);
    chk("t3_last_idx", cap[641], 12'h07F);
    clear_mon();

    // T4
    job[0] = {1'b0, 16'h0002};
    job[1] = {1'b0, 16'h0000};
    job[2] = {1'b0, 16'h0002};
    job[3] = {1'b0, 16'h0011};
    job[4] = {1'b1, 16'h0022};
    send_job(5, 1'b0);
    repeat (3) step();
    chk("t4_err_cnt", err_cnt, 1);
    chk("t4_no_burst", cap_n, 0);
    chk("t4_idle", busy, 0);
    chk("t4_ready", s_ready, 1);
    clear_mon();

    // T5
    job[0] = {1'b0, 16'h0002};
    job[1] = {1'b0, 16'h0003};
    job[2] = {1'b0, 16'h0003};
    job[3] = {1'b0, 16'h0001};
    job[4] = {1'b0, 16'h0002};
    job[5] = {1'b0, 16'h0003};
    job[6] = {1'b1, 16'h0101};
    send_job(7, 1'b0);
    repeat (3) step();
    chk("t5_err_cnt", err_cnt, 1);
    chk("t5_no_burst", cap_n, 0);
    chk("t5_idle", busy, 0);
    clear_mon();
    load_t1();
    send_job(8, 1'b0);
    wait_idle();
    check_t1("t5_next");
    clear_mon();

    // T6
    send_job(8, 1'b0);
    repeat (2) step();
    chk("t6_in_vec_valid", m_valid, 1);
    chk("t6_in_vec_val", m_val, 8'h05);
    rst = 1'b1;
    #1;
    chk("t6_rst_m_valid", m_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_ready", s_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_rel_ready", s_ready, 1);
    chk("t6_rel_m_valid", m_valid, 0);
    clear_mon();
    send_job(8, 1'b0);
    wait_idle();
    check_t1("t6_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
